mux_sel_arbiter: RTL

Round-robin arbiter that sits directly upstream of the 4-to-1 mux. It arbitrates four requesters and drives the mux select bus. It holds the chosen `sel` stable until the downstream consumer accepts the transfer through a valid/ready handshake. A wrapping transfer counter is provided for debug and verification.

---
 rtl/mux_sel_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select of a 4-to-1 mux, with a valid/ready hold and a wrapping transfer counter.
// Optional build macro MUX_SEL_ARB_PRIO0_EN gives lane 0 strict priority over the round-robin lanes 1-3.
module mux_sel_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic             out_ready,
  output logic [1:0]       sel,
  output logic [3:0]       grant,
  output logic             out_valid,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t           state_q;
  logic [1:0]       sel_q;
  logic [3:0]       grant_q;
  logic             valid_q;
  logic [1:0]       last_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       win_d;

  // Scan from last+1 to last+4; later assignments have higher priority, so iterate from farthest to nearest.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = l;
    for (int k = 4; k >= 1; k--) begin
      idx = l + k[1:0];
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  always_comb begin
`ifdef MUX_SEL_ARB_PRIO0_EN
    if (req[0]) win_d = 2'd0;
    else        win_d = rr_pick(req, last_q);
`else
    win_d = rr_pick(req, last_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= 2'b00;
      grant_q <= 4'b0000;
      valid_q <= 1'b0;
      last_q  <= 2'b11;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req != 4'b0000) begin
            sel_q   <= win_d;
            grant_q <= 4'b0001 << win_d;
            valid_q <= 1'b1;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (valid_q && out_ready) begin
`ifdef MUX_SEL_ARB_PRIO0_EN
            if (sel_q != 2'd0) last_q <= sel_q;
`else
            last_q <= sel_q;
`endif
            cnt_q   <= cnt_q + 1'b1;
            grant_q <= 4'b0000;
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= 4'b0000;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign sel       = sel_q;
  assign grant     = grant_q;
  assign out_valid = valid_q;
  assign xfer_cnt  = cnt_q;

endmodule
